// File: rtl/wt_mem_req_arbiter.sv
// Shares one memory request channel between the write-through I$ and D$, tracks
// outstanding returns per source. Define WT_ARB_DCACHE_PRIO_EN for fixed D$ priority.
module wt_mem_req_arbiter #(
   parameter int unsigned ReqWidth       = 128,
   parameter int unsigned TidWidth       = 2,
   parameter int unsigned IcacheTid      = 0,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                stall_i,
   input  logic                icache_req_i,
   output logic                icache_ack_o,
   input  logic [ReqWidth-1:0] icache_data_i,
   input  logic                dcache_req_i,
   output logic                dcache_ack_o,
   input  logic [ReqWidth-1:0] dcache_data_i,
   output logic                mem_valid_o,
   input  logic                mem_ready_i,
   output logic [ReqWidth-1:0] mem_data_o,
   output logic                mem_src_o,
   input  logic                rtrn_vld_i,
   input  logic [TidWidth-1:0] rtrn_tid_i,
   output logic                icache_rtrn_vld_o,
   output logic                dcache_rtrn_vld_o,
   output logic                busy_o,
   output logic                err_o
);

   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   typedef enum logic {IDLE, SEND} state_e;

   state_e              state, state_next;
   logic [CntWidth-1:0] icache_cnt, dcache_cnt;
   logic                icache_elig, dcache_elig;
   logic                grant_dcache, load;
   logic                icache_inc, dcache_inc, icache_dec, dcache_dec;
   logic                rtrn_is_icache;

   // A full counter blocks its requester even if a return frees a slot this cycle.
   assign icache_elig = icache_req_i && (icache_cnt < CntMax) && !stall_i;
   assign dcache_elig = dcache_req_i && (dcache_cnt < CntMax) && !stall_i;

`ifdef WT_ARB_DCACHE_PRIO_EN
   assign grant_dcache = dcache_elig;
`else
   logic last_dcache;

   assign grant_dcache = dcache_elig && (!icache_elig || !last_dcache);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_dcache <= 1'b0;
      end else if (load) begin
         last_dcache <= grant_dcache;
      end
   end
`endif

   assign load = (icache_elig || dcache_elig) && ((state == IDLE) || mem_ready_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      icache_ack_o = 1'b0;
      dcache_ack_o = 1'b0;
      if (load) begin
         state_next   = SEND;
         icache_ack_o = !grant_dcache;
         dcache_ack_o = grant_dcache;
      end else if ((state == SEND) && mem_ready_i) begin
         state_next = IDLE;
      end
   end

   assign mem_valid_o = (state == SEND);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_data_o <= '0;
         mem_src_o  <= 1'b0;
      end else if (load) begin
         mem_data_o <= grant_dcache ? dcache_data_i : icache_data_i;
         mem_src_o  <= grant_dcache;
      end
   end

   assign rtrn_is_icache    = (rtrn_tid_i == TidWidth'(IcacheTid));
   assign icache_dec        = rtrn_vld_i && rtrn_is_icache;
   assign dcache_dec        = rtrn_vld_i && !rtrn_is_icache;
   assign icache_rtrn_vld_o = icache_dec;
   assign dcache_rtrn_vld_o = dcache_dec;
   assign icache_inc        = load && !grant_dcache;
   assign dcache_inc        = load && grant_dcache;

   // A return against an empty counter is forwarded anyway but flagged permanently.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         icache_cnt <= '0;
         dcache_cnt <= '0;
         err_o      <= 1'b0;
      end else begin
         if (icache_inc && !icache_dec) begin
            icache_cnt <= icache_cnt + CntOne;
         end else if (icache_dec && !icache_inc && (icache_cnt != '0)) begin
            icache_cnt <= icache_cnt - CntOne;
         end
         if (dcache_inc && !dcache_dec) begin
            dcache_cnt <= dcache_cnt + CntOne;
         end else if (dcache_dec && !dcache_inc && (dcache_cnt != '0)) begin
            dcache_cnt <= dcache_cnt - CntOne;
         end
         if ((icache_dec && !icache_inc && (icache_cnt == '0)) ||
             (dcache_dec && !dcache_inc && (dcache_cnt == '0))) begin
            err_o <= 1'b1;
         end
      end
   end

   assign busy_o = (state == SEND) || (icache_cnt != '0) || (dcache_cnt != '0);

endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
- Shares a single memory request channel between the write-through I$ and D$ miss/write paths.
- Sits between the caches and the memory adapter (AXI or L1.5).
- Round-robin arbitration into a registered output stage with valid/ready handshake.
- Tracks outstanding transactions per requester, caps them, and routes returns back by transaction ID.

Parameters:
- ReqWidth, 128: payload width of a cache request (address, size, data, tid, type packed by caller).
- TidWidth, 2: transaction ID width.
- IcacheTid, 0: return ID that belongs to the I$; every other ID belongs to the D$.
- MaxOutstanding, 4: per-requester cap on requests awaiting a return (≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- stall_i  in  1  block new grants
- icache_req_i  in  1  I$ request, held until ack
- icache_ack_o  out  1  I$ request accepted (1-cycle pulse)
- icache_data_i  in  ReqWidth  I$ request payload
- dcache_req_i  in  1  D$ request, held until ack
- dcache_ack_o  out  1  D$ request accepted (1-cycle pulse)
- dcache_data_i  in  ReqWidth  D$ request payload
- mem_valid_o  out  1  downstream request valid
- mem_ready_i  in  1  downstream accepts
- mem_data_o  out  ReqWidth  downstream payload
- mem_src_o  out  1  source of mem_data_o (0 = I$, 1 = D$)
- rtrn_vld_i  in  1  return valid from adapter
- rtrn_tid_i  in  TidWidth  return transaction ID
- icache_rtrn_vld_o  out  1  return routed to I$
- dcache_rtrn_vld_o  out  1  return routed to D$
- busy_o  out  1  output stage occupied or any return outstanding
- err_o  out  1  sticky: return arrived with no matching outstanding request

Behaviour:
- Interface: single clock clk_i; rst_ni is asynchronous, active-low.
- Reset values: mem_valid_o=0, mem_data_o=0, mem_src_o=0, both acks 0, both counters 0, err_o=0, busy_o=0, RR pointer = "I$ last granted" (D$ wins the first conflict).
- Eligibility: a requester is eligible when its req_i=1, its counter < MaxOutstanding, and stall_i=0.
  - A counter at MaxOutstanding blocks the requester even if a return decrements it in the same cycle.
- State machine:
  - IDLE: output register empty.
  - SEND: mem_valid_o=1, holding the request.
- Load condition: `load = eligible_any && (state==IDLE || (state==SEND && mem_ready_i))`.
- Grant and timing:
  - On load, the winner's ack_o is asserted combinationally in that cycle.
  - Its payload and source are registered at the edge; mem_valid_o rises the next cycle.
  - Request-to-valid latency is 1 cycle.
- Arbitration:
  - Only one eligible requester: it wins.
  - Both eligible: the one not granted last wins.
  - The RR pointer updates on every load.
- Transitions:
  - IDLE→SEND on load.
  - SEND→SEND on mem_ready_i with load (back-to-back, 1 request/cycle throughput).
  - SEND→IDLE on mem_ready_i without load.
  - SEND holds otherwise; mem_data_o and mem_src_o stay stable while mem_valid_o=1 and mem_ready_i=0.
- stall_i:
  - Suppresses new loads only.
  - A request already in SEND stays valid until accepted.
- Outstanding counters (width clog2(MaxOutstanding+1)):
  - Increment on load for the granted source.
  - Decrement on rtrn_vld_i for the routed source.
  - Both in the same cycle: unchanged.
- Return routing (combinational, 0 latency):
  - rtrn_tid_i==IcacheTid → icache_rtrn_vld_o=rtrn_vld_i.
  - Otherwise → dcache_rtrn_vld_o=rtrn_vld_i.
  - Never both asserted.
- Underflow: a return while the routed counter is 0 (and no same-cycle increment for that source) sets err_o until reset, leaves the counter at 0, and is still forwarded.
- busy_o = (state==SEND) | (icache_cnt≠0) | (dcache_cnt≠0).
- Reset mid-operation: all state clears immediately; any in-flight request is dropped (the adapter is reset together).

Optional Feature:
- Macro: WT_ARB_DCACHE_PRIO_EN.
- Defined: fixed priority, D$ always wins when both are eligible; the RR pointer is removed.
- Undefined: round-robin as described above.

Test Plan:
- Single I$ request, mem_ready_i=1 → icache_ack_o pulses in cycle 0; mem_valid_o=1, mem_src_o=0 in cycle 1; returning IcacheTid=0 pulses icache_rtrn_vld_o; busy_o drops afterwards.
- Both requesters held continuously, mem_ready_i=1 → grants alternate D,I,D,I… (D first after reset), one per cycle; with WT_ARB_DCACHE_PRIO_EN all grants go to D$ and I$ is starved.
- mem_ready_i=0 for 5 cycles with a request loaded → mem_data_o stable; no further acks; the next ack comes in the cycle mem_ready_i=1.
- D$ issues 4 requests with no returns (MaxOutstanding=4) → 5th request not acked; a return with tid=1 frees a slot; ack follows on the next cycle.
- Return with tid=2 while dcache_cnt=0 → dcache_rtrn_vld_o=1, err_o=1 and stays 1; counter stays 0.
- stall_i=1 while I$ requests and a D$ request is in SEND → D$ request completes, no icache_ack_o until stall_i=0; assert rst_ni=0 mid-SEND → mem_valid_o=0 and busy_o=0 immediately.
